// File: rtl/rvfi_order_buffer.sv
// Order-indexed reorder window: accepts NRET retirements per cycle and emits them one per cycle in ascending order.
// Define RVFI_ORDER_BUF_BYPASS_EN to present a head-matching input on the outputs in the same cycle.
module rvfi_order_buffer #(
    parameter int NRET    = 2,
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 64
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NRET-1:0]         in_valid,
    input  logic [NRET*ORDER_W-1:0] in_order,
    input  logic [NRET*XLEN-1:0]    in_pc_rdata,
    input  logic [NRET*XLEN-1:0]    in_pc_wdata,
    input  logic [NRET*32-1:0]      in_insn,
    input  logic [NRET-1:0]         in_trap,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ORDER_W-1:0]      out_order,
    output logic [XLEN-1:0]         out_pc_rdata,
    output logic [XLEN-1:0]         out_pc_wdata,
    output logic [31:0]             out_insn,
    output logic                    out_trap,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    err_dup,
    output logic                    err_window
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [ORDER_W-1:0] order_q [DEPTH];
    logic [ORDER_W-1:0] order_d [DEPTH];
    logic [XLEN-1:0]    pc_rdata_q [DEPTH];
    logic [XLEN-1:0]    pc_rdata_d [DEPTH];
    logic [XLEN-1:0]    pc_wdata_q [DEPTH];
    logic [XLEN-1:0]    pc_wdata_d [DEPTH];
    logic [31:0]        insn_q [DEPTH];
    logic [31:0]        insn_d [DEPTH];
    logic [DEPTH-1:0]   trap_q, trap_d;
    logic [ORDER_W-1:0] next_order_q, next_order_d;
    logic               err_dup_q, err_dup_d;
    logic               err_window_q, err_window_d;

    logic [IDX_W-1:0]   head_idx;
    logic [IDX_W-1:0]   slot;
    logic [ORDER_W-1:0] ord;
    logic [DEPTH-1:0]   written;
    logic [NRET-1:0]    byp_sel;
    logic               byp_hit;
    logic               pop;
    logic [OCC_W-1:0]   occ;

    always_comb begin
        valid_d      = valid_q;
        order_d      = order_q;
        pc_rdata_d   = pc_rdata_q;
        pc_wdata_d   = pc_wdata_q;
        insn_d       = insn_q;
        trap_d       = trap_q;
        next_order_d = next_order_q;
        err_dup_d    = err_dup_q;
        err_window_d = err_window_q;
        written      = '0;
        byp_sel      = '0;
        byp_hit      = 1'b0;
        ord          = '0;
        slot         = '0;
        occ          = '0;
        head_idx     = next_order_q[IDX_W-1:0];

`ifdef RVFI_ORDER_BUF_BYPASS_EN
        if (!valid_q[head_idx]) begin
            for (int i = 0; i < NRET; i++) begin
                if (!byp_hit && in_valid[i] && in_order[i*ORDER_W +: ORDER_W] == next_order_q) begin
                    byp_hit    = 1'b1;
                    byp_sel[i] = 1'b1;
                end
            end
        end
`endif

        out_valid    = valid_q[head_idx] | byp_hit;
        out_order    = order_q[head_idx];
        out_pc_rdata = pc_rdata_q[head_idx];
        out_pc_wdata = pc_wdata_q[head_idx];
        out_insn     = insn_q[head_idx];
        out_trap     = trap_q[head_idx];
        for (int i = 0; i < NRET; i++) begin
            if (byp_sel[i]) begin
                out_order    = in_order[i*ORDER_W +: ORDER_W];
                out_pc_rdata = in_pc_rdata[i*XLEN +: XLEN];
                out_pc_wdata = in_pc_wdata[i*XLEN +: XLEN];
                out_insn     = in_insn[i*32 +: 32];
                out_trap     = in_trap[i];
            end
        end
        pop = out_valid && out_ready;

        // Window test is against the pre-pop next_order; lower channels claim slots first.
        for (int i = 0; i < NRET; i++) begin
            if (in_valid[i]) begin
                ord  = in_order[i*ORDER_W +: ORDER_W];
                slot = ord[IDX_W-1:0];
                if ((ord - next_order_q) >= ORDER_W'(DEPTH)) begin
                    err_window_d = 1'b1;
                end else if (valid_q[slot] || written[slot]) begin
                    err_dup_d = 1'b1;
                end else begin
                    written[slot] = 1'b1;
                    if (!(byp_sel[i] && out_ready)) begin
                        valid_d[slot]    = 1'b1;
                        order_d[slot]    = ord;
                        pc_rdata_d[slot] = in_pc_rdata[i*XLEN +: XLEN];
                        pc_wdata_d[slot] = in_pc_wdata[i*XLEN +: XLEN];
                        insn_d[slot]     = in_insn[i*32 +: 32];
                        trap_d[slot]     = in_trap[i];
                    end
                end
            end
        end

        // A write can never land in a valid head slot, so clearing after the writes is safe.
        if (pop) begin
            valid_d[head_idx] = 1'b0;
            next_order_d      = next_order_q + 1'b1;
        end

        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(valid_q[k]);
        end
        occupancy  = occ;
        err_dup    = err_dup_q;
        err_window = err_window_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q      <= '0;
            trap_q       <= '0;
            next_order_q <= '0;
            err_dup_q    <= 1'b0;
            err_window_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                order_q[k]    <= '0;
                pc_rdata_q[k] <= '0;
                pc_wdata_q[k] <= '0;
                insn_q[k]     <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            trap_q       <= trap_d;
            next_order_q <= next_order_d;
            err_dup_q    <= err_dup_d;
            err_window_q <= err_window_d;
            order_q      <= order_d;
            pc_rdata_q   <= pc_rdata_d;
            pc_wdata_q   <= pc_wdata_d;
            insn_q       <= insn_d;
        end
    end
endmodule

// File: doc/rvfi_order_buffer.md
Name: rvfi_order_buffer

Overview:
- Upstream stage of the per-channel PC checks.
- Accepts up to NRET retirements per cycle in arbitrary order and buffers them in an order-indexed window.
- Emits them one per cycle in strictly ascending rvfi_order, so downstream PC forward/backward checkers see a gap-free stream.
- Flags duplicate and out-of-window orders as sticky errors.

Parameters:
- NRET, 2, number of input retirement channels
- XLEN, 32, PC/instruction data width
- DEPTH, 8, window entries; power of two, >= 2
- ORDER_W, 64, width of order fields

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  NRET  per-channel retirement valid
- in_order  in  NRET*ORDER_W  per-channel order, channel i at [i*ORDER_W +: ORDER_W]
- in_pc_rdata  in  NRET*XLEN  per-channel PC of the instruction
- in_pc_wdata  in  NRET*XLEN  per-channel next PC
- in_insn  in  NRET*32  per-channel instruction word
- in_trap  in  NRET  per-channel trap flag
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_order  out  ORDER_W  head order (equals next_order)
- out_pc_rdata  out  XLEN  head PC
- out_pc_wdata  out  XLEN  head next PC
- out_insn  out  32  head instruction
- out_trap  out  1  head trap
- occupancy  out  clog2(DEPTH)+1  number of valid slots
- err_dup  out  1  sticky: slot already occupied, or two channels with the same order in one cycle
- err_window  out  1  sticky: order outside [next_order, next_order+DEPTH-1]

Behaviour:
- Reset (resetn low, asynchronous): all slot valid bits 0, next_order 0, err_dup 0, err_window 0.
  - Outputs during and after reset: out_valid 0, occupancy 0. Data outputs don't-care while out_valid is 0.
  - Reset mid-operation discards all buffered entries.
- Slot index = order[log2(DEPTH)-1:0].
  - Window test uses the full ORDER_W subtraction order - next_order, unsigned, compared against DEPTH.
  - No wrap handling beyond 2^ORDER_W.
- Write, per channel with in_valid=1, processed in ascending channel index:
  - out of window: set err_window, drop the entry;
  - else if slot valid, or already written by a lower channel this cycle: set err_dup, drop; the lower channel wins;
  - else store {order, pc_rdata, pc_wdata, insn, trap} and set slot valid at the clock edge.
- Output:
  - out_* is driven combinationally from the slot at next_order.
  - out_valid = that slot's valid bit.
  - An entry written at edge N is visible on the outputs from cycle N+1 (1-cycle latency).
- Pop: out_valid && out_ready at the edge → clear the head slot and increment next_order.
  - out_ready with out_valid=0 has no effect.
- Simultaneous pop and write:
  - the window test uses pre-pop next_order, so order next_order+DEPTH is flagged err_window even if it targets the popped slot;
  - writes to other slots proceed normally.
- Occupancy = popcount of the valid bits; it updates with writes and pops in the same edge.
- Errors are sticky until reset and do not stall output.

Optional Feature:
- Macro: RVFI_ORDER_BUF_BYPASS_EN.
- Defined: if the head slot is empty and a channel presents in_order == next_order (lowest such channel), it is presented on out_* in the same cycle (zero latency).
  - If out_ready=1, it is consumed without being stored and next_order increments.
  - If out_ready=0, it is stored normally.
  - Error checks are unchanged.
- Undefined: always the 1-cycle registered latency described above.

Test Plan:
- Reset, then ch0 order=0 pc_rdata=0x100 pc_wdata=0x104, out_ready=1 → cycle+1: out_valid=1, out_order=0, out_pc_rdata=0x100; next cycle out_valid=0, occupancy=0.
- Same cycle ch0 order=1 (pc 0x104), ch1 order=0 (pc 0x100), out_ready=1 → outputs order 0 then order 1 on consecutive cycles, pc_rdata 0x100, 0x104; no errors.
- out_ready=0; fill orders 0..7 → occupancy=8. Then present order 8 → err_window=1, occupancy stays 8. Release out_ready → orders 0..7 drain in sequence.
- Order 3 written twice in successive cycles → err_dup=1 and stays 1; the first entry is preserved and emitted with its original data.
- Both channels order=2 in one cycle → err_dup=1; ch0 data stored.
- Assert resetn low while occupancy=5 → out_valid=0, occupancy=0, errors cleared immediately; after release, order 0 is accepted again.
- Bypass build: head empty, order=0 with out_ready=1 → out_valid=1 in the same cycle; occupancy stays 0.
